sd_block_responder: RTL and testbench

// - Disk-side end of the sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_* block protocol. Serves 512-byte sector

---
 rtl/sd_block_responder.sv | 256 +++++++++++++++++++++++++
 tb/tb_sd_block_responder.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_responder.sv
// sd_block_responder: serves 512-byte block requests of the sd_* bus from a byte-wide backing memory
// and issues img_mounted pulses. Define SD_RESP_WRPROT_EN to block writes to read-only mounted drives.
module sd_block_responder #(
  parameter int VDNUM  = 3,
  parameter int LBA_W  = 11,
  parameter int MEM_AW = 22
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [31:0]       sd_lba,
  input  logic [VDNUM-1:0]  sd_rd,
  input  logic [VDNUM-1:0]  sd_wr,
  output logic [VDNUM-1:0]  sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din,
  output logic [VDNUM-1:0]  img_mounted,
  output logic              img_readonly,
  output logic [63:0]       img_size,
  input  logic              mount_stb,
  input  logic [1:0]        mount_drv,
  input  logic              mount_ro,
  input  logic [63:0]       mount_size,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);

  localparam int DW = (VDNUM > 1) ? $clog2(VDNUM) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_MEM, RD_PUT, WR_ADDR, WR_CAP, WR_MEM, DONE
  } state_t;

  state_t             state_r, state_s;
  logic [DW-1:0]      drv_r, drv_s;
  logic [LBA_W-1:0]   lba_r, lba_s;
  logic               oor_r, oor_s;
  logic [8:0]         cnt_r, cnt_s, cnt_inc_s;
  logic               pend_r;
  logic [1:0]         pend_drv_r;
  logic               pend_ro_r;
  logic [63:0]        pend_size_r;
  logic               mount_svc_s;
  logic [VDNUM-1:0]   mount_mask_s;
  logic               req_hit_s, req_rd_s;
  logic [DW-1:0]      req_drv_s;
  logic               oor_now_s;
  logic               wprot_s;
  logic [VDNUM-1:0]   ack_s, mounted_s;
  logic [8:0]         baddr_s;
  logic [7:0]         bdout_s, mwdata_s;
  logic               bwr_s, ro_s, mrd_s, mwr_s;
  logic [63:0]        size_s;
  logic [MEM_AW-1:0]  maddr_s, cur_addr_s, next_addr_s;

  assign cnt_inc_s    = cnt_r + 9'd1;
  assign cur_addr_s   = MEM_AW'({drv_r, lba_r, cnt_r});
  assign next_addr_s  = MEM_AW'({drv_r, lba_r, cnt_inc_s});
  assign oor_now_s    = |(sd_lba >> LBA_W);
  assign mount_mask_s = VDNUM'(1'b1) << pend_drv_r;

  // Fixed-priority arbiter: scanning downward leaves the lowest requesting drive; rd beats wr.
  always_comb begin
    req_hit_s = 1'b0;
    req_drv_s = '0;
    req_rd_s  = 1'b0;
    for (int i = VDNUM - 1; i >= 0; i--) begin
      req_drv_s = (sd_rd[i] | sd_wr[i]) ? DW'(i) : req_drv_s;
      req_rd_s  = (sd_rd[i] | sd_wr[i]) ? sd_rd[i] : req_rd_s;
      req_hit_s = req_hit_s | sd_rd[i] | sd_wr[i];
    end
  end

`ifdef SD_RESP_WRPROT_EN
  logic [VDNUM-1:0] ro_r;

  // Per-drive read-only bits, recorded as each mount is announced.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ro_r <= '0;
    end else if (mount_svc_s) begin
      ro_r <= pend_ro_r ? (ro_r | mount_mask_s) : (ro_r & ~mount_mask_s);
    end
  end

  assign wprot_s = |(ro_r & (VDNUM'(1'b1) << drv_r));
`else
  assign wprot_s = 1'b0;
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s     = state_r;
    drv_s       = drv_r;
    lba_s       = lba_r;
    oor_s       = oor_r;
    cnt_s       = cnt_r;
    ack_s       = sd_ack;
    baddr_s     = sd_buff_addr;
    bdout_s     = sd_buff_dout;
    bwr_s       = 1'b0;
    mounted_s   = '0;
    ro_s        = img_readonly;
    size_s      = img_size;
    maddr_s     = mem_addr;
    mrd_s       = mem_rd;
    mwr_s       = mem_wr;
    mwdata_s    = mem_wdata;
    mount_svc_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pend_r) begin
          mount_svc_s = 1'b1;
          mounted_s   = mount_mask_s;
          ro_s        = pend_ro_r;
          size_s      = pend_size_r;
        end else if (req_hit_s) begin
          drv_s   = req_drv_s;
          lba_s   = sd_lba[LBA_W-1:0];
          oor_s   = oor_now_s;
          cnt_s   = 9'd0;
          ack_s   = VDNUM'(1'b1) << req_drv_s;
          baddr_s = 9'd0;
          maddr_s = MEM_AW'({req_drv_s, sd_lba[LBA_W-1:0], 9'd0});
          if (req_rd_s) begin
            state_s = RD_MEM;
            mrd_s   = ~oor_now_s;
          end else begin
            state_s = WR_ADDR;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD_MEM: begin
        // mem_rd stays low for out-of-range sectors, so the byte completes with no wait.
        if (!mem_rd || mem_ready) begin
          state_s = RD_PUT;
          mrd_s   = 1'b0;
          bwr_s   = 1'b1;
          baddr_s = cnt_r;
          bdout_s = oor_r ? 8'hFF : mem_rdata;
        end else begin
          state_s = RD_MEM;
        end
      end
      RD_PUT: begin
        if (cnt_r == 9'd511) begin
          state_s = DONE;
          ack_s   = '0;
        end else begin
          state_s = RD_MEM;
          cnt_s   = cnt_inc_s;
          maddr_s = next_addr_s;
          mrd_s   = ~oor_r;
        end
      end
      WR_ADDR: begin
        state_s = WR_CAP;
      end
      WR_CAP: begin
        state_s  = WR_MEM;
        mwdata_s = sd_buff_din;
        maddr_s  = cur_addr_s;
        mwr_s    = ~(oor_r | wprot_s);
      end
      WR_MEM: begin
        if (!mem_wr || mem_ready) begin
          mwr_s = 1'b0;
          if (cnt_r == 9'd511) begin
            state_s = DONE;
            ack_s   = '0;
          end else begin
            state_s = WR_ADDR;
            cnt_s   = cnt_inc_s;
            baddr_s = cnt_inc_s;
          end
        end else begin
          state_s = WR_MEM;
        end
      end
      DONE: begin
        state_s = IDLE;
        cnt_s   = 9'd0;
      end
      default: begin
        state_s = IDLE;
        ack_s   = '0;
        mrd_s   = 1'b0;
        mwr_s   = 1'b0;
      end
    endcase
  end

  // State, transfer context and registered outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r      <= IDLE;
      drv_r        <= '0;
      lba_r        <= '0;
      oor_r        <= 1'b0;
      cnt_r        <= 9'd0;
      sd_ack       <= '0;
      sd_buff_addr <= 9'd0;
      sd_buff_dout <= 8'd0;
      sd_buff_wr   <= 1'b0;
      img_mounted  <= '0;
      img_readonly <= 1'b0;
      img_size     <= 64'd0;
      mem_addr     <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_wdata    <= 8'd0;
    end else begin
      state_r      <= state_s;
      drv_r        <= drv_s;
      lba_r        <= lba_s;
      oor_r        <= oor_s;
      cnt_r        <= cnt_s;
      sd_ack       <= ack_s;
      sd_buff_addr <= baddr_s;
      sd_buff_dout <= bdout_s;
      sd_buff_wr   <= bwr_s;
      img_mounted  <= mounted_s;
      img_readonly <= ro_s;
      img_size     <= size_s;
      mem_addr     <= maddr_s;
      mem_rd       <= mrd_s;
      mem_wr       <= mwr_s;
      mem_wdata    <= mwdata_s;
    end
  end

  // Single pending-mount slot; a newer valid mount overwrites an unserviced one.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend_r      <= 1'b0;
      pend_drv_r  <= 2'd0;
      pend_ro_r   <= 1'b0;
      pend_size_r <= 64'd0;
    end else if (mount_stb && ({30'd0, mount_drv} < 32'(VDNUM))) begin
      pend_r      <= 1'b1;
      pend_drv_r  <= mount_drv;
      pend_ro_r   <= mount_ro;
      pend_size_r <= mount_size;
    end else if (mount_svc_s) begin
      pend_r      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sd_block_responder.sv
// tb_sd_block_responder: directed self-checking bench for sd_block_responder (VDNUM=3, LBA_W=11, MEM_AW=22)
// with a latency-configurable byte memory and a registered initiator buffer.
module tb_sd_block_responder;
  logic        clk;
  logic        reset;
  logic [31:0] sd_lba;
  logic [2:0]  sd_rd, sd_wr, sd_ack, img_mounted;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout, sd_buff_din, mem_wdata, mem_rdata;
  logic        sd_buff_wr, img_readonly, mount_stb, mount_ro, mem_rd, mem_wr, mem_ready;
  logic [63:0] img_size, mount_size;
  logic [1:0]  mount_drv;
  logic [21:0] mem_addr;

  int checks = 0;
  int errors = 0;

  sd_block_responder dut (
    .clk_sys(clk), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din), .img_mounted(img_mounted), .img_readonly(img_readonly),
    .img_size(img_size), .mount_stb(mount_stb), .mount_drv(mount_drv), .mount_ro(mount_ro),
    .mount_size(mount_size), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory: unwritten bytes follow a fixed pattern; drive 0 sector 5 byte k reads k^0x5A.
  bit   [7:0] mem   [0:4194303];
  bit         wrote [0:4194303];
  int         mem_lat = 0;
  int         wcnt = 0;
  int         wr_total = 0;

  function automatic logic [7:0] dflt(input logic [21:0] a);
    return a[7:0] ^ 8'h5A ^ ({a[21:20], 1'b0, a[13:9]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] peek(input logic [21:0] a);
    return wrote[a] ? mem[a] : dflt(a);
  endfunction

  initial begin
    mem_ready = 1'b0;
    mem_rdata = 8'd0;
  end

  always @(posedge clk) begin
    if ((mem_rd || mem_wr) && !mem_ready) begin
      if (wcnt >= mem_lat) begin
        mem_ready <= 1'b1;
        wcnt      <= 0;
        if (mem_rd) mem_rdata <= peek(mem_addr);
        if (mem_wr) begin
          mem[mem_addr]   <= mem_wdata;
          wrote[mem_addr] <= 1'b1;
          wr_total        <= wr_total + 1;
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      mem_ready <= 1'b0;
      wcnt      <= 0;
    end
  end

  // Initiator buffer (one-cycle read latency) and read-strobe monitor.
  logic [7:0] buf_in [512];
  logic [7:0] rd_buf [512];
  logic [8:0] exp_addr = 9'd0;
  int strobes = 0, addr_bad = 0, rd_cycles = 0, mnt_cycles = 0, mnt_in_xfer = 0;

  always @(posedge clk) begin
    sd_buff_din <= buf_in[sd_buff_addr];
    if (mem_rd) rd_cycles <= rd_cycles + 1;
    if (sd_buff_wr) begin
      rd_buf[sd_buff_addr] <= sd_buff_dout;
      strobes  <= strobes + 1;
      exp_addr <= exp_addr + 9'd1;
      if (sd_buff_addr != exp_addr) addr_bad <= addr_bad + 1;
    end
    if (img_mounted != 3'b000) begin
      mnt_cycles <= mnt_cycles + 1;
      if (sd_ack != 3'b000) mnt_in_xfer <= mnt_in_xfer + 1;
    end
  end

  // Wait for a transfer to start, drop the served drive's request, and measure ack-high cycles.
  task automatic wait_xfer(output logic [2:0] seen, output int cyc);
    int n;
    seen = 3'b000;
    cyc  = 0;
    n    = 0;
    while (sd_ack == 3'b000 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sd_ack === 3'b000) begin
      errors++;
      $display("FAIL ack_start: sd_ack=%b, required nonzero within 50 cycles", sd_ack);
      sd_rd = 3'b000;
      sd_wr = 3'b000;
      return;
    end
    seen  = sd_ack;
    sd_rd = sd_rd & ~sd_ack;
    sd_wr = sd_wr & ~sd_ack;
    cyc   = 1;
    forever begin
      @(negedge clk);
      if (sd_ack == 3'b000) break;
      cyc++;
      if (cyc > 20000) begin
        errors++;
        $display("FAIL ack_end: sd_ack still %b after 20000 cycles", sd_ack);
        break;
      end
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({sd_ack, sd_buff_wr, mem_rd, mem_wr, img_mounted, img_readonly} !== 10'd0) begin
      errors++;
      $display("FAIL reset_ctrl: ack=%b bwr=%b rd=%b wr=%b mnt=%b ro=%b, required all 0",
               sd_ack, sd_buff_wr, mem_rd, mem_wr, img_mounted, img_readonly);
    end
    checks++;
    if ({sd_buff_addr, sd_buff_dout, mem_wdata} !== 25'd0) begin
      errors++;
      $display("FAIL reset_buff: addr=%h dout=%h wdata=%h, required 0", sd_buff_addr, sd_buff_dout, mem_wdata);
    end
    checks++;
    if (mem_addr !== 22'd0) begin
      errors++;
      $display("FAIL reset_mem_addr: got %h, required 0", mem_addr);
    end
    checks++;
    if (img_size !== 64'd0) begin
      errors++;
      $display("FAIL reset_img_size: got %0d, required 0", img_size);
    end
  endtask

  task automatic test_read;
    logic [2:0] seen;
    int cyc, s0, r0, w0, a0, bad;
    s0 = strobes; r0 = rd_cycles; w0 = wr_total; a0 = addr_bad;
    sd_lba = 32'd5;
    sd_rd  = 3'b001;
    wait_xfer(seen, cyc);
    checks++;
    if (seen !== 3'b001) begin errors++; $display("FAIL read_ack: got %b, required 001", seen); end
    checks++;
    if (cyc != 1536) begin errors++; $display("FAIL read_cycles: got %0d, required 1536", cyc); end
    checks++;
    if (strobes - s0 != 512) begin errors++; $display("FAIL read_strobes: got %0d, required 512", strobes - s0); end
    checks++;
    if (addr_bad != a0) begin errors++; $display("FAIL read_addr_order: %0d out-of-order strobes, required 0", addr_bad - a0); end
    bad = 0;
    for (int k = 0; k < 512; k++) begin
      logic [8:0] kk;
      kk = 9'(k);
      if (rd_buf[k] !== (kk[7:0] ^ 8'h5A)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL read_data: %0d bad bytes (byte0=%h), required 0 (byte0=5a)", bad, rd_buf[0]); end
    checks++;
    if (rd_cycles - r0 != 1024 || wr_total != w0) begin
      errors++;
      $display("FAIL read_mem_use: rd cycles %0d writes %0d, required 1024 and 0", rd_cycles - r0, wr_total - w0);
    end
  endtask

  task automatic test_write;
    logic [2:0] seen;
    int cyc, s0, w0, bad;
    for (int k = 0; k < 512; k++) begin
      logic [8:0] kk;
      kk = 9'(k);
      buf_in[k] = ~kk[7:0];
    end
    mem_lat = 2;
    s0 = strobes; w0 = wr_total;
    sd_lba = 32'd2;
    sd_wr  = 3'b010;
    wait_xfer(seen, cyc);
    checks++;
    if (seen !== 3'b010) begin errors++; $display("FAIL write_ack: got %b, required 010", seen); end
    checks++;
    if (cyc != 3072) begin errors++; $display("FAIL write_cycles: got %0d, required 3072", cyc); end
    checks++;
    if (wr_total - w0 != 512 || strobes != s0) begin
      errors++;
      $display("FAIL write_count: writes %0d strobes %0d at ack drop, required 512 and 0", wr_total - w0, strobes - s0);
    end
    bad = 0;
    for (int k = 0; k < 512; k++) begin
      logic [8:0] kk;
      kk = 9'(k);
      if (!wrote[{2'd1, 11'd2, kk}] || peek({2'd1, 11'd2, kk}) !== ~kk[7:0]) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL write_data: %0d bad bytes (byte0=%h), required 0 (byte0=ff)", bad, peek({2'd1, 11'd2, 9'd0})); end
    mem_lat = 0;
  endtask

  task automatic test_back_to_back;
    logic [2:0] seen;
    int cyc, w0, bad;
    w0 = wr_total;
    sd_lba = 32'd3;
    sd_rd  = 3'b110;
    sd_wr  = 3'b010;
    for (int d = 1; d <= 2; d++) begin
      wait_xfer(seen, cyc);
      checks++;
      if (seen !== 3'(1 << d) || cyc != 1536) begin
        errors++;
        $display("FAIL prio_ack%0d: ack %b cycles %0d, required %b and 1536", d, seen, cyc, 3'(1 << d));
      end
      bad = 0;
      for (int k = 0; k < 512; k++) begin
        if (rd_buf[k] !== dflt({2'(d), 11'd3, 9'(k)})) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL prio_data%0d: %0d bad bytes, required 0", d, bad); end
    end
    checks++;
    if (wr_total != w0) begin errors++; $display("FAIL prio_no_write: %0d writes, required 0", wr_total - w0); end
  endtask

  task automatic test_out_of_range;
    logic [2:0] seen;
    int cyc, r0, w0, bad;
    r0 = rd_cycles; w0 = wr_total;
    sd_lba = 32'h0001_0000;
    sd_rd  = 3'b001;
    wait_xfer(seen, cyc);
    bad = 0;
    for (int k = 0; k < 512; k++) if (rd_buf[k] !== 8'hFF) bad++;
    checks++;
    if (bad != 0 || cyc != 1024) begin errors++; $display("FAIL oor_read: %0d non-FF bytes, %0d cycles, required 0 and 1024", bad, cyc); end
    checks++;
    if (rd_cycles != r0) begin errors++; $display("FAIL oor_mem_rd: mem_rd high %0d cycles, required 0", rd_cycles - r0); end
    sd_lba = 32'h0000_0800;
    sd_wr  = 3'b001;
    wait_xfer(seen, cyc);
    checks++;
    if (wr_total != w0 || cyc != 1536) begin
      errors++;
      $display("FAIL oor_write: %0d writes, %0d cycles, required 0 and 1536", wr_total - w0, cyc);
    end
    sd_lba = 32'h0000_07FF;
    sd_rd  = 3'b100;
    wait_xfer(seen, cyc);
    bad = 0;
    for (int k = 0; k < 512; k++) if (rd_buf[k] !== dflt({2'd2, 11'h7FF, 9'(k)})) bad++;
    checks++;
    if (bad != 0 || cyc != 1536) begin errors++; $display("FAIL max_lba_read: %0d bad bytes, %0d cycles, required 0 and 1536", bad, cyc); end
  endtask

  task automatic test_mount_mid_read;
    int n, m0, x0, s0;
    logic [2:0] seen;
    int cyc;
    m0 = mnt_cycles; x0 = mnt_in_xfer; s0 = strobes;
    sd_lba = 32'd5;
    sd_rd  = 3'b001;
    n = 0;
    while (sd_ack == 3'b000 && n < 50) begin @(negedge clk); n++; end
    sd_rd = 3'b000;
    n = 0;
    while (strobes - s0 < 100 && n < 2000) begin @(negedge clk); n++; end
    mount_drv  = 2'd2;
    mount_size = 64'd92176;
    mount_ro   = 1'b1;
    mount_stb  = 1'b1;
    @(negedge clk);
    mount_stb  = 1'b0;
    wait_xfer(seen, cyc);
    checks++;
    if (mnt_cycles != m0 || cyc < 1000) begin
      errors++;
      $display("FAIL mount_deferred: %0d pulse cycles before ack drop (ack cycles %0d), required 0", mnt_cycles - m0, cyc);
    end
    n = 0;
    while (img_mounted == 3'b000 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (img_mounted !== 3'b100 || img_size !== 64'd92176 || img_readonly !== 1'b1) begin
      errors++;
      $display("FAIL mount_pulse: mnt=%b size=%0d ro=%b, required 100 92176 1", img_mounted, img_size, img_readonly);
    end
    @(negedge clk);
    checks++;
    if (img_mounted !== 3'b000 || mnt_cycles - m0 != 1 || mnt_in_xfer != x0) begin
      errors++;
      $display("FAIL mount_one_cycle: mnt=%b pulse cycles %0d in-xfer %0d, required 000 1 0",
               img_mounted, mnt_cycles - m0, mnt_in_xfer - x0);
    end
  endtask

  task automatic test_mount_invalid;
    int m0;
    m0 = mnt_cycles;
    mount_drv  = 2'd3;
    mount_size = 64'd5;
    mount_ro   = 1'b0;
    mount_stb  = 1'b1;
    @(negedge clk);
    mount_stb  = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (mnt_cycles != m0 || img_size !== 64'd92176 || img_readonly !== 1'b1) begin
      errors++;
      $display("FAIL mount_invalid: pulses %0d size %0d ro %b, required 0 92176 1", mnt_cycles - m0, img_size, img_readonly);
    end
  endtask

  task automatic test_write_protect;
    logic [2:0] seen;
    int cyc, w0, exp_w, exp_c;
`ifdef SD_RESP_WRPROT_EN
    exp_w = 0;   exp_c = 1536;
`else
    exp_w = 512; exp_c = 2048;
`endif
    w0 = wr_total;
    sd_lba = 32'd1;
    sd_wr  = 3'b100;
    wait_xfer(seen, cyc);
    checks++;
    if (wr_total - w0 != exp_w || cyc != exp_c) begin
      errors++;
      $display("FAIL wrprot: %0d writes %0d cycles, required %0d and %0d", wr_total - w0, cyc, exp_w, exp_c);
    end
  endtask

  task automatic test_reset_mid_write;
    logic [2:0] seen;
    int n, w0, cyc, bad;
    w0 = wr_total;
    sd_lba = 32'd6;
    sd_wr  = 3'b010;
    n = 0;
    while (sd_ack == 3'b000 && n < 50) begin @(negedge clk); n++; end
    sd_wr = 3'b000;
    n = 0;
    while (wr_total - w0 < 200 && n < 5000) begin @(negedge clk); n++; end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({sd_ack, mem_wr, mem_rd, sd_buff_wr} !== 6'd0 || img_size !== 64'd0) begin
      errors++;
      $display("FAIL reset_abort: ack=%b wr=%b rd=%b bwr=%b size=%0d, required all 0",
               sd_ack, mem_wr, mem_rd, sd_buff_wr, img_size);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wrote[{2'd1, 11'd6, 9'd300}] || wr_total - w0 > 201) begin
      errors++;
      $display("FAIL reset_stop_writes: %0d writes, byte300 written=%b, required <=201 and 0",
               wr_total - w0, wrote[{2'd1, 11'd6, 9'd300}]);
    end
    sd_lba = 32'd5;
    sd_rd  = 3'b001;
    wait_xfer(seen, cyc);
    bad = 0;
    for (int k = 0; k < 512; k++) begin
      logic [8:0] kk;
      kk = 9'(k);
      if (rd_buf[k] !== (kk[7:0] ^ 8'h5A)) bad++;
    end
    checks++;
    if (seen !== 3'b001 || cyc != 1536 || bad != 0) begin
      errors++;
      $display("FAIL reset_recover: ack %b cycles %0d bad %0d, required 001 1536 0", seen, cyc, bad);
    end
  endtask

  initial begin
    reset = 1'b1;
    sd_lba = 32'd0; sd_rd = 3'b000; sd_wr = 3'b000;
    mount_stb = 1'b0; mount_drv = 2'd0; mount_ro = 1'b0; mount_size = 64'd0;
    for (int k = 0; k < 512; k++) buf_in[k] = 8'd0;
    repeat (3) @(negedge clk);
    test_reset;
    reset = 1'b0;
    @(negedge clk);
    test_read;
    @(negedge clk);
    test_write;
    @(negedge clk);
    test_back_to_back;
    @(negedge clk);
    test_out_of_range;
    @(negedge clk);
    test_mount_mid_read;
    test_mount_invalid;
    test_write_protect;
    @(negedge clk);
    test_reset_mid_write;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
